fruta_ctrl: RTL and testbench
=============================

# fruta_ctrl

Fruit placement controller for the snake game, sitting between the fruit coordinate generator and the map RAM. When a game starts or a fruit is eaten, it pulses the generator's `fruta_enable` and captures the proposed cell. It then reads the map to confirm the cell is empty. On success it writes the fruit code into the map; on failure it retries with a new proposal. It also holds the current fruit position for the collision and render logic.

## Interface
- `MAPA_WIDTH`, 40, map width in cells
- `MAPA_HEIGHT`, 30, map height in cells
- `MAX_TRIES`, 16, generator proposals per placement before giving up (1..255)
- `FRUTA_CODE`, 2'd3, cell code written for a fruit; code 2'd0 is empty
---
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; place the first fruit of a game
- `comeu`  in  1  one-cycle pulse; the snake ate the current fruit
- `fruta_enable`  out  1  request to the generator
- `fruta_write`  in  1  generator proposal valid
- `fruta_xw`  in  10  proposed x
- `fruta_yw`  in  10  proposed y
- `mapa_addr`  out  11  map address, y*MAPA_WIDTH+x
- `mapa_rdata`  in  2  map cell code, valid 1 cycle after `mapa_addr`
- `mapa_we`  out  1  map write strobe
- `mapa_wdata`  out  2  map write data
- `fruta_x`, `fruta_y`  out  10 each  current fruit cell
- `fruta_valid`  out  1  a fruit is on the map
- `busy`  out  1  placement in progress
- `falhou`  out  1  one-cycle pulse; placement abandoned

## Operation
- States: IDLE, REQ, WAIT, READ, CHECK, WRITE, plus SCAN_RD and SCAN_CK when the macro is enabled.
- IDLE → REQ when `start`, `comeu` or the pending flag is set. Clear the pending flag and load the try counter with 0.
- REQ: `fruta_enable`=1 for exactly one cycle. WAIT: `fruta_enable`=0.
  - The generator holds its state while enabled, so it advances only in WAIT.
- WAIT: when `fruta_write`=1, capture `fruta_xw`/`fruta_yw` and go to READ. If `fruta_write`=0, stay in WAIT.
- READ: drive the registered `mapa_addr` for the captured cell.
- CHECK: the cell is free if `mapa_rdata`==0 and x<MAPA_WIDTH and y<MAPA_HEIGHT.
  - Out-of-range coordinates count as occupied.
- CHECK, free → WRITE.
- CHECK, occupied → increment the try counter.
  - Counter reaches MAX_TRIES: pulse `falhou` and go to IDLE (SCAN_RD with the macro).
  - Otherwise go back to REQ.
- WRITE: `mapa_we`=1, `mapa_wdata`=FRUTA_CODE, address unchanged. Update `fruta_x`/`fruta_y`, set `fruta_valid`, go to IDLE.
- `comeu` clears `fruta_valid` on the next edge in any state. The controller never clears the old map cell; the snake logic overwrites it.
- `start` or `comeu` while `busy`: set the single pending flag. Further pulses are absorbed.
- `busy`=1 in every state except IDLE.

## Timing
- Reset: every output is 0, the state is IDLE, and the pending flag and try counter are cleared. This holds from any state, including mid-CHECK; no `mapa_we` is issued after reset.
- First attempt: trigger at edge N; REQ at N+1, WAIT N+2, READ N+3, CHECK N+4, WRITE N+5.
- `mapa_we` is high during the cycle after edge N+5; `fruta_valid` rises at edge N+6.
- Each retry adds 4 cycles (REQ..CHECK).
- `falhou` is high for exactly one cycle, in the cycle after the final CHECK.
- `fruta_enable` is never high in two consecutive cycles.
- When `comeu` and the WRITE edge coincide, `comeu` wins: `fruta_valid` ends 0 and the pending flag is set.

## Configuration
- `FRUTA_CTRL_SCAN_EN` defined: after MAX_TRIES failures, scan linearly from address 0 upward.
  - Each cell takes 2 cycles: SCAN_RD drives the address, SCAN_CK tests `mapa_rdata`.
  - Track x/y counters in row-major order.
  - The first empty cell goes to WRITE.
  - `falhou` pulses only if all MAPA_WIDTH*MAPA_HEIGHT cells are occupied.
- Not defined: the SCAN states are absent; exhaustion pulses `falhou` directly and places no fruit.

## Test plan
- Empty map, `start` at edge 0, generator proposes (5,7) → `mapa_we` at addr 285 with wdata 3 after edge 5; `fruta_x`=5, `fruta_y`=7, `fruta_valid`=1 at edge 6.
- Cell (5,7) marked as snake (1), second proposal (12,3) → exactly two `fruta_enable` pulses, write to addr 132, 4 extra cycles.
- MAX_TRIES=4, every proposal occupied, macro off → `falhou` pulse after the 4th CHECK; no `mapa_we`; `fruta_valid`=0.
- Macro on, map full except addr 1199 → fruit written at (39,29); `falhou` never asserted.
- `comeu` pulsed twice during a busy placement → exactly one extra placement follows; `fruta_valid` low in between.
- `reset` asserted in the CHECK cycle → the next cycle shows all outputs 0 and IDLE; no write occurs.

Source files
------------

// File: rtl/fruta_ctrl_if.sv
// Generator handshake and map RAM port of the fruit placement controller.
// The controller side uses the master modport; the generator/RAM side uses slave.
interface fruta_ctrl_if;
  logic        fruta_enable;
  logic        fruta_write;
  logic [9:0]  fruta_xw;
  logic [9:0]  fruta_yw;
  logic [10:0] mapa_addr;
  logic [1:0]  mapa_rdata;
  logic        mapa_we;
  logic [1:0]  mapa_wdata;

  modport master (
    output fruta_enable, mapa_addr, mapa_we, mapa_wdata,
    input  fruta_write, fruta_xw, fruta_yw, mapa_rdata
  );

  modport slave (
    input  fruta_enable, mapa_addr, mapa_we, mapa_wdata,
    output fruta_write, fruta_xw, fruta_yw, mapa_rdata
  );
endinterface

// File: rtl/fruta_ctrl.sv
// Fruit placement controller: requests cells from the generator, checks the map, writes the fruit.
// Define FRUTA_CTRL_SCAN_EN to fall back to a linear map scan after MAX_TRIES failed proposals.
module fruta_ctrl #(
  parameter int         MAPA_WIDTH  = 40,
  parameter int         MAPA_HEIGHT = 30,
  parameter int         MAX_TRIES   = 16,
  parameter logic [1:0] FRUTA_CODE  = 2'd3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         comeu,
  fruta_ctrl_if.master bus,
  output logic [9:0]   fruta_x,
  output logic [9:0]   fruta_y,
  output logic         fruta_valid,
  output logic         busy,
  output logic         falhou
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, READ, CHECK, WRITE
`ifdef FRUTA_CTRL_SCAN_EN
    , SCAN_RD, SCAN_CK
`endif
  } state_t;

  state_t      state, next_state;
  logic        pending;
  logic [7:0]  tries;
  logic [9:0]  cap_x, cap_y;
  logic        trigger, cell_free, last_try;

  assign trigger   = start || comeu || pending;
  // Out-of-range proposals are treated exactly like occupied cells.
  assign cell_free = (bus.mapa_rdata == 2'd0) &&
                     (int'(cap_x) < MAPA_WIDTH) && (int'(cap_y) < MAPA_HEIGHT);
  assign last_try  = (int'(tries) == MAX_TRIES - 1);

`ifdef FRUTA_CTRL_SCAN_EN
  logic scan_last;
  assign scan_last = (int'(cap_x) == MAPA_WIDTH - 1) && (int'(cap_y) == MAPA_HEIGHT - 1);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    next_state       = state;
    bus.fruta_enable = 1'b0;
    bus.mapa_we      = 1'b0;
    bus.mapa_wdata   = 2'd0;
    busy             = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (trigger) next_state = REQ;
      end
      REQ: begin
        bus.fruta_enable = 1'b1;
        next_state       = WAIT;
      end
      WAIT:  if (bus.fruta_write) next_state = READ;
      READ:  next_state = CHECK;
      CHECK: begin
        if (cell_free)     next_state = WRITE;
`ifdef FRUTA_CTRL_SCAN_EN
        else if (last_try) next_state = SCAN_RD;
`else
        else if (last_try) next_state = IDLE;
`endif
        else               next_state = REQ;
      end
      WRITE: begin
        bus.mapa_we    = 1'b1;
        bus.mapa_wdata = FRUTA_CODE;
        next_state     = IDLE;
      end
`ifdef FRUTA_CTRL_SCAN_EN
      SCAN_RD: next_state = SCAN_CK;
      SCAN_CK: begin
        if (bus.mapa_rdata == 2'd0) next_state = WRITE;
        else if (scan_last)         next_state = IDLE;
        else                        next_state = SCAN_RD;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending       <= 1'b0;
      tries         <= '0;
      cap_x         <= '0;
      cap_y         <= '0;
      bus.mapa_addr <= '0;
      fruta_x       <= '0;
      fruta_y       <= '0;
      fruta_valid   <= 1'b0;
      falhou        <= 1'b0;
    end else begin
      falhou <= 1'b0;
      if (state != IDLE && (start || comeu)) pending <= 1'b1;

      case (state)
        IDLE: if (trigger) begin
          pending <= 1'b0;
          tries   <= '0;
        end
        WAIT: if (bus.fruta_write) begin
          cap_x         <= bus.fruta_xw;
          cap_y         <= bus.fruta_yw;
          bus.mapa_addr <= 11'(int'(bus.fruta_yw) * MAPA_WIDTH + int'(bus.fruta_xw));
        end
        CHECK: if (!cell_free) begin
          tries <= tries + 1'b1;
          if (last_try) begin
`ifdef FRUTA_CTRL_SCAN_EN
            cap_x         <= '0;
            cap_y         <= '0;
            bus.mapa_addr <= '0;
`else
            falhou <= 1'b1;
`endif
          end
        end
`ifdef FRUTA_CTRL_SCAN_EN
        SCAN_CK: if (bus.mapa_rdata != 2'd0) begin
          if (scan_last) begin
            falhou <= 1'b1;
          end else begin
            bus.mapa_addr <= bus.mapa_addr + 1'b1;
            if (int'(cap_x) == MAPA_WIDTH - 1) begin
              cap_x <= '0;
              cap_y <= cap_y + 1'b1;
            end else begin
              cap_x <= cap_x + 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase

      if (state == WRITE) begin
        fruta_x <= cap_x;
        fruta_y <= cap_y;
      end
      // A simultaneous eat beats the write: the fresh fruit is considered already eaten.
      if (comeu)               fruta_valid <= 1'b0;
      else if (state == WRITE) fruta_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fruta_ctrl.sv
// Self-checking bench for fruta_ctrl: directed timing cases plus randomized placements
// scored against a map/proposal reference model.
module tb_fruta_ctrl;
  localparam int         W  = 40;
  localparam int         H  = 30;
  localparam int         MT = 4;
  localparam logic [1:0] FC = 2'd3;

  logic       clk = 1'b0;
  logic       reset, start, comeu;
  logic [9:0] fruta_x, fruta_y;
  logic       fruta_valid, busy, falhou;

  fruta_ctrl_if bus ();

  fruta_ctrl #(.MAPA_WIDTH(W), .MAPA_HEIGHT(H), .MAX_TRIES(MT), .FRUTA_CODE(FC)) dut (
    .clk(clk), .reset(reset), .start(start), .comeu(comeu), .bus(bus),
    .fruta_x(fruta_x), .fruta_y(fruta_y), .fruta_valid(fruta_valid),
    .busy(busy), .falhou(falhou)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Environment state: map contents and proposal list owned by the stimulus thread.
  logic [1:0] mem [0:2047];
  int px [0:255];
  int py [0:255];
  int gen_dmax = 0;

  // Monitor-owned event log.
  int cyc = 0, p_idx = 0;
  int en_cnt = 0, we_cnt = 0, fal_cnt = 0, we_cyc = 0, fal_cyc = 0, rise_cyc = 0;
  logic [10:0] we_addr = '0;
  logic [1:0]  we_data = '0;

  // Generator and RAM responder plus event monitor, sampling 1 time unit after each edge.
  initial begin
    logic [10:0] prev_addr;
    logic        prev_en, prev_valid, gen_pend;
    int          gen_cnt;
    prev_addr = '0; prev_en = 1'b0; prev_valid = 1'b0; gen_pend = 1'b0; gen_cnt = 0;
    bus.fruta_write = 1'b0; bus.fruta_xw = '0; bus.fruta_yw = '0; bus.mapa_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.mapa_rdata = mem[prev_addr];
      prev_addr      = bus.mapa_addr;
      if (bus.mapa_we) begin
        we_cnt++; we_cyc = cyc; we_addr = bus.mapa_addr; we_data = bus.mapa_wdata;
      end
      if (falhou) begin fal_cnt++; fal_cyc = cyc; end
      if (fruta_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = fruta_valid;
      bus.fruta_write = 1'b0;
      if (gen_pend) begin
        if (gen_cnt == 0) begin
          bus.fruta_write = 1'b1;
          bus.fruta_xw    = 10'(px[p_idx % 256]);
          bus.fruta_yw    = 10'(py[p_idx % 256]);
          p_idx++;
          gen_pend = 1'b0;
        end else gen_cnt--;
      end
      if (bus.fruta_enable) begin
        check("en_gap", 32'(prev_en), 32'd0);
        en_cnt++;
        gen_pend = 1'b1;
        gen_cnt  = int'($urandom_range(0, gen_dmax));
      end
      prev_en = bus.fruta_enable;
    end
  end

  int b_en, b_we, b_fal, p_base, t0;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic mark();
    b_en = en_cnt; b_we = we_cnt; b_fal = fal_cnt; p_base = p_idx; t0 = cyc;
  endtask

  task automatic set_prop(input int i, input int x, input int y);
    px[(p_base + i) % 256] = x;
    py[(p_base + i) % 256] = y;
  endtask

  task automatic clear_map();
    foreach (mem[i]) mem[i] = 2'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit done);
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin done = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_en"},    32'(bus.fruta_enable), 0);
    check({tag, "_we"},    32'(bus.mapa_we), 0);
    check({tag, "_wdata"}, 32'(bus.mapa_wdata), 0);
    check({tag, "_addr"},  32'(bus.mapa_addr), 0);
    check({tag, "_x"},     32'(fruta_x), 0);
    check({tag, "_y"},     32'(fruta_y), 0);
    check({tag, "_valid"}, 32'(fruta_valid), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_fal"},   32'(falhou), 0);
  endtask

  // Reference: first free in-range proposal wins; otherwise the scan (if built) takes the
  // lowest free address; otherwise the placement is abandoned.
  function automatic void predict(output bit ok, output int tries, output int addr);
    ok = 1'b0; tries = MT; addr = 0;
    for (int i = 0; i < MT; i++) begin
      int x, y;
      x = px[(p_base + i) % 256];
      y = py[(p_base + i) % 256];
      if (x < W && y < H && mem[y * W + x] == 2'd0) begin
        ok = 1'b1; tries = i + 1; addr = y * W + x;
        return;
      end
    end
`ifdef FRUTA_CTRL_SCAN_EN
    for (int a = 0; a < W * H; a++)
      if (mem[a] == 2'd0) begin ok = 1'b1; addr = a; return; end
`endif
  endfunction

  initial begin
    bit done, ok;
    int tries, addr, exp_x, exp_y;
    logic exp_valid;

    reset = 1'b1; start = 1'b0; comeu = 1'b0;
    clear_map();
    foreach (px[i]) begin px[i] = 0; py[i] = 0; end
    tick(2);
    check_zero("rst");
    reset = 1'b0;
    tick(1);

    // Empty map, single proposal (5,7).
    mark(); set_prop(0, 5, 7);
    pulse_start(); wait_idle(100, done);
    check("p1_done", 32'(done), 1);
    check("p1_we_n", 32'(we_cnt - b_we), 1);
    check("p1_addr", 32'(we_addr), 285);
    check("p1_wdata", 32'(we_data), 3);
    check("p1_we_cyc", 32'(we_cyc - t0), 5);
    check("p1_valid_cyc", 32'(rise_cyc - t0), 6);
    check("p1_x", 32'(fruta_x), 5);
    check("p1_y", 32'(fruta_y), 7);
    check("p1_valid", 32'(fruta_valid), 1);
    check("p1_en_n", 32'(en_cnt - b_en), 1);

    // First proposal occupied by the snake, retry lands on (12,3).
    clear_map(); mem[285] = 2'd1;
    mark(); set_prop(0, 5, 7); set_prop(1, 12, 3);
    pulse_start(); wait_idle(100, done);
    check("p2_done", 32'(done), 1);
    check("p2_en_n", 32'(en_cnt - b_en), 2);
    check("p2_addr", 32'(we_addr), 132);
    check("p2_we_cyc", 32'(we_cyc - t0), 9);

    // Range boundary: x=40 rejected even though its aliased cell is empty; (39,29) accepted.
    clear_map();
    mark(); set_prop(0, 40, 29); set_prop(1, 39, 29);
    pulse_start(); wait_idle(100, done);
    check("bnd_en_n", 32'(en_cnt - b_en), 2);
    check("bnd_addr", 32'(we_addr), 1199);
    check("bnd_x", 32'(fruta_x), 39);
    check("bnd_y", 32'(fruta_y), 29);

    // Every proposal occupied or out of range.
    reset = 1'b1; tick(1); reset = 1'b0;
    clear_map(); mem[10] = 2'd1; mem[500] = 2'd2;
    mark(); set_prop(0, 10, 0); set_prop(1, 20, 12); set_prop(2, 40, 0); set_prop(3, 0, 30);
    predict(ok, tries, addr);
    pulse_start(); wait_idle(4000, done);
    check("ex_done", 32'(done), 1);
    check("ex_en_n", 32'(en_cnt - b_en), MT);
    check("ex_we_n", 32'(we_cnt - b_we), 32'(ok));
    check("ex_fal_n", 32'(fal_cnt - b_fal), 32'(!ok));
    check("ex_valid", 32'(fruta_valid), 32'(ok));
`ifdef FRUTA_CTRL_SCAN_EN
    check("ex_addr", 32'(we_addr), 32'(addr));
    check("ex_we_cyc", 32'(we_cyc - t0), 19);

    // Scan fallback with only the last cell free.
    clear_map();
    for (int a = 0; a < W * H - 1; a++) mem[a] = 2'd1;
    mark(); for (int i = 0; i < MT; i++) set_prop(i, i, 0);
    pulse_start(); wait_idle(6000, done);
    check("scan_done", 32'(done), 1);
    check("scan_addr", 32'(we_addr), 1199);
    check("scan_x", 32'(fruta_x), 39);
    check("scan_y", 32'(fruta_y), 29);
    check("scan_fal_n", 32'(fal_cnt - b_fal), 0);
`else
    check("ex_fal_cyc", 32'(fal_cyc - t0), 17);
`endif

    // Eat while a placement is running: two extra eats collapse into one extra placement.
    clear_map(); gen_dmax = 0;
    mark(); set_prop(0, 1, 1);
    pulse_start(); wait_idle(100, done);
    check("eat_pre_valid", 32'(fruta_valid), 1);
    mark(); set_prop(0, 2, 2); set_prop(1, 3, 3);
    comeu = 1'b1; tick(1); comeu = 1'b0;
    check("eat_clear", 32'(fruta_valid), 0);
    tick(1);
    comeu = 1'b1; tick(2); comeu = 1'b0;
    check("eat_low", 32'(fruta_valid), 0);
    tick(30);
    check("eat_we_n", 32'(we_cnt - b_we), 2);
    check("eat_en_n", 32'(en_cnt - b_en), 2);
    check("eat_addr", 32'(we_addr), 123);
    check("eat_valid", 32'(fruta_valid), 1);

    // Eat on the same edge that leaves WRITE.
    mark(); set_prop(0, 4, 4); set_prop(1, 6, 6);
    pulse_start(); tick(4);
    check("co_we", 32'(bus.mapa_we), 1);
    comeu = 1'b1; tick(1); comeu = 1'b0;
    check("co_valid", 32'(fruta_valid), 0);
    tick(1);
    check("co_pend", 32'(busy), 1);
    tick(10);
    check("co_we_n", 32'(we_cnt - b_we), 2);
    check("co_x", 32'(fruta_x), 6);
    check("co_valid2", 32'(fruta_valid), 1);

    // Reset landing in the CHECK cycle.
    clear_map();
    mark(); set_prop(0, 8, 8);
    pulse_start(); tick(3);
    reset = 1'b1; tick(1);
    check_zero("rchk");
    reset = 1'b0;
    tick(10);
    check("rchk_we_n", 32'(we_cnt - b_we), 0);
    check("rchk_busy", 32'(busy), 0);

    // Randomized placements against the reference model.
    exp_valid = 1'b0; exp_x = 0; exp_y = 0;
    gen_dmax = 3;
    for (int t = 0; t < 12; t++) begin
      int dens;
      clear_map();
      dens = int'($urandom_range(0, 3));
      foreach (mem[i]) if (int'($urandom_range(0, 3)) < dens) mem[i] = 2'd1;
      mark();
      for (int i = 0; i < MT; i++)
        set_prop(i, int'($urandom_range(0, 45)), int'($urandom_range(0, 33)));
      predict(ok, tries, addr);
      pulse_start(); wait_idle(6000, done);
      check("rnd_done", 32'(done), 1);
      check("rnd_en_n", 32'(en_cnt - b_en), 32'(tries));
      check("rnd_we_n", 32'(we_cnt - b_we), 32'(ok));
      check("rnd_fal_n", 32'(fal_cnt - b_fal), 32'(!ok));
      if (ok) begin
        check("rnd_addr", 32'(we_addr), 32'(addr));
        exp_valid = 1'b1; exp_x = addr % W; exp_y = addr / W;
      end
      check("rnd_x", 32'(fruta_x), 32'(exp_x));
      check("rnd_y", 32'(fruta_y), 32'(exp_y));
      check("rnd_valid", 32'(fruta_valid), 32'(exp_valid));
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
